// File: rtl/arb_pkg.sv
// Shared types, mode encodings and helpers for the N-requester arbiter.
package arb_pkg;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

  localparam int ARB_MAX_N = 16;
  localparam int ARB_HCW   = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  // Returns an ARB_MAX_N-wide one-hot; callers size-cast down to their N.
  function automatic logic [ARB_MAX_N-1:0] onehot(input int idx, input int n);
    logic [ARB_MAX_N-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n) v = ARB_MAX_N'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner search: fixed lowest-index or round-robin after last_id.
// Zero latency; purely combinational, no flow control.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_masked,
  input  logic [IDW-1:0] last_id,
  input  logic           rr_mode,
  output logic           found,
  output logic [IDW-1:0] win_id
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  int             w_start;

  // Doubling the vector turns the wrap-around search into a plain shift.
  always_comb begin
    w_start = 0;
    if (rr_mode == ARB_MODE_RR) w_start = (int'(last_id) + 1) % N;
    w_dbl  = {req_masked, req_masked};
    w_rot  = N'(w_dbl >> w_start);
    found  = 1'b0;
    win_id = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && w_rot[i]) begin
        found  = 1'b1;
        win_id = IDW'((w_start + i) % N);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-requester arbiter, fixed or round-robin, with bounded grant hold.
// Latency 1 cycle from sampled req to registered grant; no backpressure.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           rr_mode,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);

  localparam logic [ARB_HCW-1:0] HOLD_MAX = ARB_HCW'(MAX_HOLD);
  localparam logic [ARB_HCW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? '1 : HOLD_MAX;

  arb_state_t         r_state,  w_nxt_state;
  logic [N-1:0]       r_grant,  w_nxt_grant;
  logic               r_grant_valid, w_nxt_grant_valid;
  logic [IDW-1:0]     r_grant_id, w_nxt_grant_id;
  logic [IDW-1:0]     r_last_id, w_nxt_last_id;
  logic [ARB_HCW-1:0] r_hold_cnt, w_nxt_hold_cnt;

  logic [N-1:0]   w_own_oh, w_win_oh, w_others, w_pick_req;
  logic           w_holding, w_expired, w_rotate, w_found;
  logic [IDW-1:0] w_win_id;

  assign w_own_oh   = N'(onehot(int'(r_grant_id), N));
  assign w_win_oh   = N'(onehot(int'(w_win_id), N));
  assign w_others   = req & ~w_own_oh;
  assign w_holding  = (r_state == ARB_BUSY) && |(req & w_own_oh);
  // While the owner still requests, only the others compete (rotation).
  assign w_pick_req = w_holding ? w_others : req;
  assign w_expired  = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_MAX);
  assign w_rotate   = w_holding && w_expired && w_found;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req_masked (w_pick_req),
    .last_id    (r_last_id),
    .rr_mode    (rr_mode),
    .found      (w_found),
    .win_id     (w_win_id)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ARB_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_last_id     <= IDW'(N - 1);
      r_hold_cnt    <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_grant       <= w_nxt_grant;
      r_grant_valid <= w_nxt_grant_valid;
      r_grant_id    <= w_nxt_grant_id;
      r_last_id     <= w_nxt_last_id;
      r_hold_cnt    <= w_nxt_hold_cnt;
    end
  end

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_grant       = r_grant;
    w_nxt_grant_valid = r_grant_valid;
    w_nxt_grant_id    = r_grant_id;
    w_nxt_last_id     = r_last_id;
    w_nxt_hold_cnt    = r_hold_cnt;
    if (!w_holding || w_rotate) begin
      if (w_found) begin
        w_nxt_state       = ARB_BUSY;
        w_nxt_grant       = w_win_oh;
        w_nxt_grant_valid = 1'b1;
        w_nxt_grant_id    = w_win_id;
        w_nxt_last_id     = w_win_id;
        w_nxt_hold_cnt    = ARB_HCW'(1);
      end else begin
        w_nxt_state       = ARB_IDLE;
        w_nxt_grant       = '0;
        w_nxt_grant_valid = 1'b0;
        w_nxt_grant_id    = '0;
        w_nxt_hold_cnt    = '0;
      end
    end else if (r_hold_cnt != HOLD_SAT) begin
      w_nxt_hold_cnt = r_hold_cnt + ARB_HCW'(1);
    end
  end

  always_comb begin
    grant       = r_grant;
    grant_valid = r_grant_valid;
    grant_id    = r_grant_id;
  end

  a_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(grant));
  a_valid:  assert property (@(posedge clock) disable iff (!reset) grant_valid == |grant);
  a_id:     assert property (@(posedge clock) disable iff (!reset) grant_valid |-> grant[grant_id]);
  a_stable: assert property (@(posedge clock) disable iff (!reset)
                             (w_holding && !w_rotate) |=> $stable(grant));

endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
- N-requester arbiter with registered one-hot grants.
- Parametrised successor to the team's 2-requester R0/R1 → G0/G1 arbiter FSM.
- Adds a runtime-selectable mode, fixed-priority or round-robin.
- Adds a bounded grant hold, so a requester holding req high cannot starve the others.
- Sits in front of a shared resource (bus, memory port), one req/grant pair per client.

Parameters:
- N, 4: number of requesters, legal range 2..16.
- MAX_HOLD, 8: maximum consecutive grant cycles while another requester waits. 0 = unlimited; legal range 0..255.
- IDW, $clog2(N): width of grant_id (derived, not overridden).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N  request vector; bit i = requester i wants the resource.
- rr_mode  in  1  1 = round-robin, 0 = fixed priority (lowest index wins).
- grant  out  N  registered one-hot grant; all-zero when idle.
- grant_valid  out  1  registered; equals |grant.
- grant_id  out  IDW  registered index of the granted requester; 0 when idle.

Behaviour:
- Reset (reset=0, asynchronous):
  - grant=0, grant_valid=0, grant_id=0, state=IDLE, hold_cnt=0.
  - last_id=N-1, so index 0 holds top round-robin priority after reset.
- States:
  - IDLE: no owner.
  - BUSY: owner = grant_id.
- All decisions are made at a rising clock edge from the sampled req. Grant is visible one cycle after req is sampled (latency 1).
- Pick function over candidate set C:
  - fixed mode: lowest set index in C.
  - RR mode: first set index in C searching last_id+1, last_id+2, … with wrap modulo N.
  - C empty → no winner.
- IDLE:
  - req≠0 → grant pick(req), go to BUSY, hold_cnt=1, last_id=winner.
  - Otherwise stay in IDLE.
- BUSY, owner k:
  - req[k]=0 (release):
    - If req≠0, grant pick(req) at the same edge: no dead cycle, hold_cnt=1.
    - Otherwise go to IDLE: grant=0, hold_cnt=0.
  - req[k]=1, MAX_HOLD≠0, hold_cnt==MAX_HOLD, and (req & ~onehot(k))≠0 → forced rotation:
    - grant pick(req & ~onehot(k)), hold_cnt=1.
  - req[k]=1 otherwise → keep grant.
    - hold_cnt increments, saturating at MAX_HOLD.
    - A later arriving requester therefore preempts on the first edge it is sampled if the count is already saturated.
- last_id updates on every new grant in both modes. Fixed mode ignores it for picking.
- rr_mode change takes effect at the next decision (new grant or rotation). An active grant is never dropped by a mode change.
- Invariants, checked by assertions:
  - $onehot0(grant).
  - grant_valid==|grant.
  - When grant_valid=1, grant[grant_id]=1.
  - A grant never changes without a release or a forced rotation.
- Reset asserted mid-grant: outputs clear immediately (asynchronous). The first arbitration after deassertion starts from index 0.
- Req bits of non-owners may toggle freely. Only the sampled value at the edge matters.

Decomposition:
- Package arb_pkg:
  - ARB_MODE_FIXED=1'b0, ARB_MODE_RR=1'b1.
  - State enum {ARB_IDLE, ARB_BUSY}.
  - Function onehot(idx, N).
- Sub-module rr_pick: combinational winner search with inputs (req_masked, last_id, rr_mode) and outputs (found, win_id).
  - Instantiated once.
  - Implemented as a double-width rotated priority encoder.
- The top level holds the FSM, hold counter and output registers.

Test Plan (N=4, MAX_HOLD=4, rr_mode=1 unless stated):
1. Reset, then req=4'b1111 held steady → grants cycle 0,1,2,3,0 with each owner granted exactly 4 cycles; grant_id follows; one-hot throughout.
2. Fixed mode, req=4'b1010, requester 1 holds → grant=0010 for 4 cycles, then rotation to 1000 (only other candidate); after 4 more cycles back to 0010 (lowest among others).
3. req=4'b0100 alone for 20 cycles → grant=0100 continuously, no rotation. Assert req[0] at cycle 10 → grant moves to 0001 on the first edge after req[0] is sampled (hold saturated).
4. Owner 2 drops req while req=4'b1001 → next edge grant=1000 (RR after last_id=2), no idle cycle. Then all req=0 → grant=0, grant_valid=0, grant_id=0.
5. Pulse reset low mid-grant (owner 3) → grant clears asynchronously. After release with req=4'b1111 → first grant=0001.
6. Toggle rr_mode 1→0 while owner 2 holds with req=4'b1111 → owner 2 retains the grant until hold expiry, then grant=0001 (fixed rule).
